// File: rtl/three_parallel_fir.sv
// 3-parallel direct-form FIR: three sub-filters share one TAPS-1 sample history
// and produce y[3m], y[3m+1], y[3m+2] every clock, registered at full precision.
module three_parallel_fir #(
    parameter int                 TAPS   = 9,
    parameter logic [TAPS*16-1:0] COEFFS = {16'sd9, 16'sd8, 16'sd7, 16'sd6, 16'sd5,
                                            16'sd4, 16'sd3, 16'sd2, 16'sd1}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] din1,
    input  logic signed [15:0] din2,
    input  logic signed [15:0] din3,
    output logic signed [63:0] dout1,
    output logic signed [63:0] dout2,
    output logic signed [63:0] dout3
);

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int PROD_W = DATA_W + COEF_W;
    // One guard bit beyond clog2(TAPS) so a sum of TAPS extreme products never wraps.
    localparam int ACC_W  = PROD_W + $clog2(TAPS) + 1;
    localparam int OUT_W  = 64;
    localparam int HIST   = TAPS - 1;
    localparam int WIN    = TAPS + 2;

    function automatic logic signed [COEF_W-1:0] coef(input int k);
        return $signed(COEFFS[k*COEF_W +: COEF_W]);
    endfunction

    function automatic logic signed [ACC_W-1:0] mac(
        input logic signed [ACC_W-1:0]  acc,
        input logic signed [COEF_W-1:0] h,
        input logic signed [DATA_W-1:0] x
    );
        logic signed [PROD_W-1:0] p;
        p = PROD_W'(h) * PROD_W'(x);
        return acc + ACC_W'(p);
    endfunction

    function automatic logic signed [OUT_W-1:0] sext_out(input logic signed [ACC_W-1:0] a);
        return OUT_W'(a);
    endfunction

    logic signed [DATA_W-1:0] hist_q [HIST];
    logic signed [DATA_W-1:0] hist_d [HIST];
    logic signed [DATA_W-1:0] win    [WIN];
    logic signed [OUT_W-1:0]  y_q    [3];
    logic signed [OUT_W-1:0]  y_d    [3];

    // Window = stored history (oldest first) followed by the three new samples.
    always_comb begin
        for (int i = 0; i < HIST; i++) begin
            win[i] = hist_q[i];
        end
        win[HIST]     = din1;
        win[HIST + 1] = din2;
        win[HIST + 2] = din3;
    end

    always_comb begin
        logic signed [ACC_W-1:0] acc;
        for (int j = 0; j < 3; j++) begin
            acc = '0;
            for (int i = 0; i < TAPS; i++) begin
                acc = mac(acc, coef(i), win[HIST + j - i]);
            end
            y_d[j] = sext_out(acc);
        end
        for (int i = 0; i < HIST; i++) begin
            hist_d[i] = win[i + 3];
        end
    end

    // Stage boundary: history and outputs register on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '{default: '0};
            y_q    <= '{default: '0};
        end else begin
            hist_q <= hist_d;
            y_q    <= y_d;
        end
    end

    assign dout1 = y_q[0];
    assign dout2 = y_q[1];
    assign dout3 = y_q[2];

endmodule

// File: tb/tb_three_parallel_fir.sv
// Directed and golden-model checks for three_parallel_fir, default taps plus an
// all -32768 coefficient instance for the overflow corner.
module tb_three_parallel_fir;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] din1 = '0;
    logic signed [15:0] din2 = '0;
    logic signed [15:0] din3 = '0;
    logic signed [63:0] dout1, dout2, dout3;
    logic signed [63:0] xout1, xout2, xout3;

    int n_checks = 0;
    int n_errors = 0;
    shortint xs[$];

    localparam longint P = 64'sd1073741824;

    always #5 clk = ~clk;

    three_parallel_fir dut (
        .clk(clk), .rst(rst), .din1(din1), .din2(din2), .din3(din3),
        .dout1(dout1), .dout2(dout2), .dout3(dout3)
    );

    three_parallel_fir #(.TAPS(9), .COEFFS({9{16'h8000}})) dut_x (
        .clk(clk), .rst(rst), .din1(din1), .din2(din2), .din3(din3),
        .dout1(xout1), .dout2(xout2), .dout3(xout3)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a block now, let the next rising edge take it, sample 1 ns later.
    task automatic drive_block(input logic signed [15:0] a, input logic signed [15:0] b,
                               input logic signed [15:0] c);
        din1 = a;
        din2 = b;
        din3 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string tag,
                       input logic signed [15:0] a, input logic signed [15:0] b,
                       input logic signed [15:0] c,
                       input longint e1, input longint e2, input longint e3);
        drive_block(a, b, c);
        check({tag, ".y0"}, dout1, e1);
        check({tag, ".y1"}, dout2, e2);
        check({tag, ".y2"}, dout3, e3);
    endtask

    task automatic xvec(input string tag,
                        input longint e1, input longint e2, input longint e3);
        drive_block(-16'sd32768, -16'sd32768, -16'sd32768);
        check({tag, ".y0"}, xout1, e1);
        check({tag, ".y1"}, xout2, e2);
        check({tag, ".y2"}, xout3, e3);
    endtask

    task automatic sync_reset_cycle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic longint model_y(input int n);
        longint s = 0;
        for (int i = 0; i < 9; i++) begin
            if (n - i >= 0) s += longint'(i + 1) * longint'(xs[n - i]);
        end
        return s;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with random inputs: outputs stay at zero.
        for (int k = 0; k < 3; k++) begin
            din1 = 16'($urandom);
            din2 = 16'($urandom);
            din3 = 16'($urandom);
            @(posedge clk);
            #1;
            check("rst.d1", dout1, 0);
            check("rst.d2", dout2, 0);
            check("rst.d3", dout3, 0);
            check("rst.x1", xout1, 0);
        end
        rst = 1'b0;

        vec("imp1.b0", 1, 0, 0, 1, 2, 3);
        vec("imp1.b1", 0, 0, 0, 4, 5, 6);
        vec("imp1.b2", 0, 0, 0, 7, 8, 9);
        vec("imp1.b3", 0, 0, 0, 0, 0, 0);
        vec("imp1.b4", 0, 0, 0, 0, 0, 0);

        vec("imp2.b0", 0, 1, 0, 0, 1, 2);
        vec("imp2.b1", 0, 0, 0, 3, 4, 5);
        vec("imp2.b2", 0, 0, 0, 6, 7, 8);
        vec("imp2.b3", 0, 0, 0, 9, 0, 0);
        vec("imp2.b4", 0, 0, 0, 0, 0, 0);

        vec("step.b0", 1, 1, 1, 1, 3, 6);
        vec("step.b1", 1, 1, 1, 10, 15, 21);
        vec("step.b2", 1, 1, 1, 28, 36, 45);
        vec("step.b3", 1, 1, 1, 45, 45, 45);
        // 1 -> -1: y = 45 - 2 * (partial coefficient sum of the -1 samples).
        vec("neg.b0", -1, -1, -1, 43, 39, 33);
        vec("neg.b1", -1, -1, -1, 25, 15, 3);
        vec("neg.b2", -1, -1, -1, -11, -27, -45);
        vec("neg.b3", -1, -1, -1, -45, -45, -45);

        sync_reset_cycle();
        xvec("ext.b0", P, 2 * P, 3 * P);
        xvec("ext.b1", 4 * P, 5 * P, 6 * P);
        xvec("ext.b2", 7 * P, 8 * P, 9 * P);
        xvec("ext.b3", 9 * P, 9 * P, 9 * P);
        xvec("ext.b4", 64'sd9663676416, 64'sd9663676416, 64'sd9663676416);

        // Random stream against the direct-form model, with an async reset pulse mid-run.
        sync_reset_cycle();
        xs.delete();
        for (int b = 0; b < 10000; b++) begin
            logic signed [15:0] a, bb, c;
            int n0;
            a  = 16'($urandom);
            bb = 16'($urandom);
            c  = 16'($urandom);
            drive_block(a, bb, c);
            xs.push_back(shortint'(a));
            xs.push_back(shortint'(bb));
            xs.push_back(shortint'(c));
            n0 = xs.size() - 3;
            check("rnd.y0", dout1, model_y(n0));
            check("rnd.y1", dout2, model_y(n0 + 1));
            check("rnd.y2", dout3, model_y(n0 + 2));
            if (b == 5000) begin
                #3;
                rst = 1'b1;
                #1;
                check("arst.d1", dout1, 0);
                check("arst.d2", dout2, 0);
                check("arst.d3", dout3, 0);
                din1 = 16'($urandom);
                din2 = 16'($urandom);
                din3 = 16'($urandom);
                @(posedge clk);
                #1;
                check("arst.hold", dout1, 0);
                rst = 1'b0;
                xs.delete();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
